// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    StArb     = 3'd0,
    StIssue   = 3'd1,
    StWaitLow = 3'd2,
    StWaitRdy = 3'd3,
    StGap     = 3'd4
  } arb_state_e;

  localparam int unsigned BurstCntW = 8;
  localparam int unsigned GapCntW   = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr, with wrap.
module uart_tx_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   winner,
  output logic              any
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [IdxW:0] cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!any && req_valid[cand[IdxW-1:0]]) begin
        any    = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin scheduler feeding one FIFO-less UART transmitter.
// Optional inter-packet idle gap is enabled by defining UART_TX_ARB_GAP_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [8*NUM_REQ-1:0]              req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              txrdy,
  output logic [7:0]                        tx_hold_reg,
  output logic                              rst_tx_empty,
  output logic [idx_width(NUM_REQ)-1:0]     grant_id,
  output logic                              busy,
  output logic                              burst_abort
);

  localparam int unsigned           IdxW     = idx_width(NUM_REQ);
  localparam logic [BurstCntW-1:0]  BurstMax = BurstCntW'(MAX_BURST);
  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_max_burst
    $error("MAX_BURST must be 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_chk_gap
    $error("GAP_CYCLES must be 1..65535");
  end

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [BurstCntW-1:0] burst_q, burst_d;
  logic                 last_q, last_d;
  logic [7:0]           hold_q, hold_d;
  logic                 strobe_q, strobe_d;
  logic                 abort_q, abort_d;

  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic [IdxW-1:0]      next_ptr;
  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 pkt_done;

`ifdef UART_TX_ARB_GAP_EN
  localparam logic [GapCntW-1:0] GapLoad = GapCntW'(GAP_CYCLES - 1);
  logic [GapCntW-1:0]   gap_q, gap_d;
`endif

  uart_tx_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .winner    (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdxW'(i)) begin
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign next_ptr  = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
  // A byte that is both last and the burst limit ends the packet normally.
  assign pkt_done  = last_q || (burst_q == BurstMax);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    last_d    = last_q;
    hold_d    = hold_q;
    strobe_d  = 1'b0;
    abort_d   = 1'b0;
    req_ready = '0;
`ifdef UART_TX_ARB_GAP_EN
    gap_d     = gap_q;
`endif

    unique case (state_q)
      StArb: begin
        if (txrdy && pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        req_ready[grant_q] = txrdy & sel_valid;
        if (txrdy && sel_valid) begin
          hold_d   = sel_data;
          strobe_d = 1'b1;
          last_d   = sel_last;
          burst_d  = burst_q + 8'd1;
          state_d  = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!txrdy) begin
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (txrdy) begin
          if (pkt_done) begin
            ptr_d   = next_ptr;
            abort_d = ~last_q;
`ifdef UART_TX_ARB_GAP_EN
            gap_d   = GapLoad;
            state_d = StGap;
`else
            state_d = StArb;
`endif
          end else begin
            state_d = StIssue;
          end
        end
      end
`ifdef UART_TX_ARB_GAP_EN
      StGap: begin
        if (gap_q == '0) begin
          state_d = StArb;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
`endif
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StArb;
      ptr_q    <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      last_q   <= 1'b0;
      hold_q   <= '0;
      strobe_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      strobe_q <= strobe_d;
      abort_q  <= abort_d;
    end
  end

`ifdef UART_TX_ARB_GAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign tx_hold_reg  = hold_q;
  assign rst_tx_empty = strobe_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != StArb);
  assign burst_abort  = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple txrdy model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        txrdy;
  logic [7:0]  tx_hold_reg;
  logic        rst_tx_empty;
  logic [1:0]  grant_id;
  logic        busy;
  logic        burst_abort;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .MAX_BURST  (4),
    .GAP_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .txrdy        (txrdy),
    .tx_hold_reg  (tx_hold_reg),
    .rst_tx_empty (rst_tx_empty),
    .grant_id     (grant_id),
    .busy         (busy),
    .burst_abort  (burst_abort)
  );

  always #5 clk = ~clk;

  // Transmitter model: txrdy falls the cycle after the strobe, rises 10 cycles later.
  int low_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txrdy   <= 1'b1;
      low_cnt <= 0;
    end else if (rst_tx_empty) begin
      txrdy   <= 1'b0;
      low_cnt <= 10;
    end else if (low_cnt != 0) begin
      low_cnt <= low_cnt - 1;
      if (low_cnt == 1) txrdy <= 1'b1;
    end
  end

  // Requester model: per-source byte queues of {last, data}.
  logic [8:0] rq [4][$];
  logic [3:0] acc_drv;
  always begin
    @(posedge clk);
    acc_drv = req_ready & req_valid;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc_drv[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // Event log gathered on every active edge.
  logic [7:0] st_data [$];
  logic [1:0] st_gid [$];
  int         acc_cyc [$];
  int         rise_cyc [$];
  int         cyc = 0;
  int         strobe_bad = 0;
  int         ready_bad = 0;
  int         abort_cnt = 0;
  int         abort_busy = 0;
  logic       txrdy_prev = 1'b1;

  always @(posedge clk) begin
    txrdy_prev <= txrdy;
    if (reset_n) begin
      cyc <= cyc + 1;
      if (rst_tx_empty) begin
        st_data.push_back(tx_hold_reg);
        st_gid.push_back(grant_id);
        if (!txrdy) strobe_bad <= strobe_bad + 1;
      end
      if (burst_abort) begin
        abort_cnt <= abort_cnt + 1;
        if (busy) abort_busy <= abort_busy + 1;
      end
      if ((req_ready != 4'b0 && req_ready != (4'b1 << grant_id)) ||
          ((req_ready & ~{4{txrdy}}) != 4'b0)) ready_bad <= ready_bad + 1;
      if ((req_ready & req_valid) != 4'b0) acc_cyc.push_back(cyc);
      if (txrdy && !txrdy_prev) rise_cyc.push_back(cyc);
    end
  end

  task automatic push(input int idx, input logic [7:0] d, input logic last);
    rq[idx].push_back({last, d});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_strobes(input int base, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (st_data.size() >= base + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (!busy && txrdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    total++; if (tx_hold_reg !== 8'h00) begin bad++;
      $display("FAIL reset_hold: got %h want 00", tx_hold_reg); end
    total++; if (rst_tx_empty !== 1'b0) begin bad++;
      $display("FAIL reset_strobe: got %b want 0", rst_tx_empty); end
    total++; if (req_ready !== 4'b0) begin bad++;
      $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (grant_id !== 2'd0) begin bad++;
      $display("FAIL reset_grant: got %0d want 0", grant_id); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (burst_abort !== 1'b0) begin bad++;
      $display("FAIL reset_abort: got %b want 0", burst_abort); end
    reset_dut();
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_d [3] = '{8'h55, 8'hA3, 8'h0F};
    int sb, sbad, ab;
    bit ok;
    reset_dut();
    sb = st_data.size(); sbad = strobe_bad; ab = abort_cnt;
    push(0, 8'h55, 1'b0); push(0, 8'hA3, 1'b0); push(0, 8'h0F, 1'b1);
    wait_strobes(sb, 3, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got %0d strobes want 3",
      st_data.size() - sb); end
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (st_data.size() - sb != 3) begin bad++;
      $display("FAIL single_count: got %0d want 3", st_data.size() - sb); end
    for (int k = 0; k < 3; k++) begin
      total++; if (st_data[sb+k] !== exp_d[k]) begin bad++;
        $display("FAIL single_byte%0d: got %h want %h", k, st_data[sb+k], exp_d[k]); end
    end
    total++; if (strobe_bad != sbad) begin bad++;
      $display("FAIL single_strobe_low: got %0d want 0", strobe_bad - sbad); end
    total++; if (abort_cnt != ab) begin bad++;
      $display("FAIL single_abort: got %0d want 0", abort_cnt - ab); end
  endtask

  task automatic test_two_requesters();
    logic [7:0] exp_d [4] = '{8'h11, 8'h12, 8'h21, 8'h22};
    logic [1:0] exp_g [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
    int sb, rb;
    bit ok;
    reset_dut();
    sb = st_data.size(); rb = ready_bad;
    @(negedge clk);
    push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
    wait_strobes(sb, 4, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL two_timeout: got %0d strobes want 4",
      st_data.size() - sb); end
    wait_idle(100, ok);
    for (int k = 0; k < 4; k++) begin
      total++; if (st_gid[sb+k] !== exp_g[k] || st_data[sb+k] !== exp_d[k]) begin bad++;
        $display("FAIL two_order%0d: got grant %0d byte %h want grant %0d byte %h",
                 k, st_gid[sb+k], st_data[sb+k], exp_g[k], exp_d[k]); end
    end
    total++; if (ready_bad != rb) begin bad++;
      $display("FAIL two_ready_exclusive: got %0d bad cycles want 0", ready_bad - rb); end
    total++; if (grant_id !== 2'd2) begin bad++;
      $display("FAIL two_last_grant: got %0d want 2", grant_id); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int sb;
    bit ok;
    reset_dut();
    sb = st_data.size();
    @(negedge clk);
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1); push(0, 8'hA4, 1'b1);
    wait_strobes(sb, 5, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rot_timeout: got %0d strobes want 5",
      st_data.size() - sb); end
    for (int k = 0; k < 5; k++) begin
      total++; if (st_gid[sb+k] !== exp_g[k] || st_data[sb+k] !== exp_d[k]) begin bad++;
        $display("FAIL rot_order%0d: got grant %0d byte %h want grant %0d byte %h",
                 k, st_gid[sb+k], st_data[sb+k], exp_g[k], exp_d[k]); end
    end
  endtask

  task automatic test_burst_abort();
    logic [1:0] exp_g [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1};
    logic [7:0] exp_d [8] = '{8'h01, 8'h61, 8'h62, 8'h63, 8'h64, 8'h31, 8'h65, 8'h66};
    int sb, ab, abb;
    bit ok;
    reset_dut();
    sb = st_data.size(); ab = abort_cnt; abb = abort_busy;
    @(negedge clk);
    push(0, 8'h01, 1'b1);
    for (int k = 0; k < 6; k++) push(1, 8'h61 + 8'(k), 1'b0);
    push(3, 8'h31, 1'b1);
    wait_strobes(sb, 8, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_timeout: got %0d strobes want 8",
      st_data.size() - sb); end
    repeat (15) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      total++; if (st_gid[sb+k] !== exp_g[k] || st_data[sb+k] !== exp_d[k]) begin bad++;
        $display("FAIL burst_order%0d: got grant %0d byte %h want grant %0d byte %h",
                 k, st_gid[sb+k], st_data[sb+k], exp_g[k], exp_d[k]); end
    end
    total++; if (abort_cnt - ab != 1) begin bad++;
      $display("FAIL burst_abort_count: got %0d want 1", abort_cnt - ab); end
`ifdef UART_TX_ARB_GAP_EN
    total++; if (abort_busy - abb != 1) begin bad++;
      $display("FAIL burst_abort_state: got %0d busy pulses want 1", abort_busy - abb); end
`else
    total++; if (abort_busy - abb != 0) begin bad++;
      $display("FAIL burst_abort_state: got %0d busy pulses want 0", abort_busy - abb); end
`endif
  endtask

  task automatic test_reset_mid();
    int sb;
    bit ok;
    reset_dut();
    sb = st_data.size();
    @(negedge clk);
    push(3, 8'h3C, 1'b1);
    wait_strobes(sb, 1, 100, ok);
    repeat (4) @(posedge clk);
    #3;
    total++; if (busy !== 1'b1 || txrdy !== 1'b0) begin bad++;
      $display("FAIL mid_precond: got busy=%b txrdy=%b want 1 0", busy, txrdy); end
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    #1;
    total++; if (tx_hold_reg !== 8'h00 || rst_tx_empty !== 1'b0 || grant_id !== 2'd0)
      begin bad++; $display("FAIL mid_reset_regs: got hold=%h strobe=%b grant=%0d want 00 0 0",
                            tx_hold_reg, rst_tx_empty, grant_id); end
    total++; if (busy !== 1'b0 || burst_abort !== 1'b0 || req_ready !== 4'b0) begin bad++;
      $display("FAIL mid_reset_flags: got busy=%b abort=%b ready=%b want 0 0 0000",
               busy, burst_abort, req_ready); end
    push(3, 8'h3D, 1'b1);
    push(1, 8'h1D, 1'b1);
    repeat (3) @(negedge clk);
    sb = st_data.size();
    reset_n = 1'b1;
    wait_strobes(sb, 2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout: got %0d strobes want 2",
      st_data.size() - sb); end
    total++; if (st_gid[sb] !== 2'd1 || st_data[sb] !== 8'h1D) begin bad++;
      $display("FAIL mid_first_grant: got grant %0d byte %h want grant 1 byte 1d",
               st_gid[sb], st_data[sb]); end
    total++; if (st_gid[sb+1] !== 2'd3 || st_data[sb+1] !== 8'h3D) begin bad++;
      $display("FAIL mid_second_grant: got grant %0d byte %h want grant 3 byte 3d",
               st_gid[sb+1], st_data[sb+1]); end
  endtask

  task automatic test_gap();
    int ab, rb, sb, delta, want;
    bit ok;
`ifdef UART_TX_ARB_GAP_EN
    want = 18;
`else
    want = 2;
`endif
    reset_dut();
    sb = st_data.size(); ab = acc_cyc.size(); rb = rise_cyc.size();
    @(negedge clk);
    push(0, 8'h70, 1'b1);
    push(1, 8'h71, 1'b1);
    wait_strobes(sb, 2, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL gap_timeout: got %0d strobes want 2",
      st_data.size() - sb); end
    delta = acc_cyc[ab+1] - rise_cyc[rb];
    total++; if (delta != want) begin bad++;
      $display("FAIL gap_spacing: got %0d cycles rise-to-accept want %0d", delta, want); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_two_requesters();
    test_rotation();
    test_burst_abort();
    test_reset_mid();
    test_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
